// File: rtl/regfile_wb_queue.sv
// Write-back queue for a 4x16 register file: buffers execute-stage writes, drains one per cycle
// through a registered write port, and forwards pending data to two read lookups.
module regfile_wb_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_reg,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rf_stall,
  output logic [ADDR_W-1:0]        rf_wreg,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     rf_write_en,
  input  logic [ADDR_W-1:0]        q_reg1,
  input  logic [ADDR_W-1:0]        q_reg2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_W-1:0]        fwd1,
  output logic [DATA_W-1:0]        fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rf_wreg_q, rf_wreg_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              rf_en_q, rf_en_d;
  logic              push, pop;

  assign wb_ready    = !reset && (count_q < CNT_W'(DEPTH));
  assign push        = wb_valid && wb_ready && !flush;
  assign pop         = (count_q != '0) && !rf_stall && !flush;
  assign rf_wreg     = rf_wreg_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_write_en = rf_en_q;
  assign count       = count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rf_wreg_d  = rf_wreg_q;
    rf_wdata_d = rf_wdata_q;
    rf_en_d    = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d     = head_q + 1'b1;
        rf_wreg_d  = reg_mem_q[head_q];
        rf_wdata_d = data_mem_q[head_q];
        rf_en_d    = 1'b1;
      end
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_wreg_q  <= '0;
      rf_wdata_q <= '0;
      rf_en_q    <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_wreg_q  <= rf_wreg_d;
      rf_wdata_q <= rf_wdata_d;
      rf_en_q    <= rf_en_d;
    end
  end

  // Storage needs no reset: count gates which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem_q[tail_q]  <= wb_reg;
      data_mem_q[tail_q] <= wb_data;
    end
  end

  // Scan oldest to youngest so the youngest match overrides; output stage is the weakest candidate.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    if (rf_en_q && rf_wreg_q == q_reg1) begin
      hit1 = 1'b1;
      fwd1 = rf_wdata_q;
    end
    if (rf_en_q && rf_wreg_q == q_reg2) begin
      hit2 = 1'b1;
      fwd2 = rf_wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count_q)) begin
        if (reg_mem_q[head_q + PTR_W'(k)] == q_reg1) begin
          hit1 = 1'b1;
          fwd1 = data_mem_q[head_q + PTR_W'(k)];
        end
        if (reg_mem_q[head_q + PTR_W'(k)] == q_reg2) begin
          hit2 = 1'b1;
          fwd2 = data_mem_q[head_q + PTR_W'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized plus directed bench for regfile_wb_queue with a queue-based reference model and write scoreboard.
module tb_regfile_wb_queue;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rf_stall = 1'b0;
  logic [AW-1:0] rf_wreg;
  logic [DW-1:0] rf_wdata;
  logic          rf_write_en;
  logic [AW-1:0] q_reg1 = '0;
  logic [AW-1:0] q_reg2 = '0;
  logic          hit1, hit2;
  logic [DW-1:0] fwd1, fwd2;
  logic [2:0]    count;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_stall(rf_stall), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata), .rf_write_en(rf_write_en),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t pend_q[$];   // accepted, not yet handed to the register file
  ent_t exp_wr[$];   // scoreboard of writes the register file must see, in order
  logic m_en = 1'b0;
  ent_t m_out = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of pending writes plus the last-issued write.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q.delete();
      exp_wr.delete();
      m_en  <= 1'b0;
      m_out <= '0;
    end else if (flush) begin
      pend_q.delete();
      m_en <= 1'b0;
    end else begin
      automatic bit   accept = wb_valid && (pend_q.size() < D);
      automatic ent_t w;
      if (pend_q.size() > 0 && !rf_stall) begin
        w = pend_q.pop_front();
        exp_wr.push_back(w);
        m_en  <= 1'b1;
        m_out <= w;
      end else begin
        m_en <= 1'b0;
      end
      if (accept) pend_q.push_back('{r: wb_reg, d: wb_data});
    end
  end

  function automatic void lookup(input logic [AW-1:0] q, output logic h, output logic [DW-1:0] f);
    h = 1'b0;
    f = '0;
    if (m_en && m_out.r == q) begin
      h = 1'b1;
      f = m_out.d;
    end
    foreach (pend_q[i]) begin
      if (pend_q[i].r == q) begin
        h = 1'b1;
        f = pend_q[i].d;
      end
    end
  endfunction

  // Monitor: compares every cycle on the falling edge, popping the scoreboard on each strobe.
  always @(negedge clk) begin
    automatic logic          eh1, eh2;
    automatic logic [DW-1:0] ef1, ef2;
    automatic ent_t          w;
    lookup(q_reg1, eh1, ef1);
    lookup(q_reg2, eh2, ef2);
    chk("wb_ready", 32'(wb_ready), 32'(!reset && pend_q.size() < D));
    chk("count", 32'(count), 32'(pend_q.size()));
    chk("rf_write_en", 32'(rf_write_en), 32'(m_en));
    chk("rf_wreg_hold", 32'(rf_wreg), 32'(m_out.r));
    chk("rf_wdata_hold", 32'(rf_wdata), 32'(m_out.d));
    chk("hit1", 32'(hit1), 32'(eh1));
    chk("fwd1", 32'(fwd1), 32'(ef1));
    chk("hit2", 32'(hit2), 32'(eh2));
    chk("fwd2", 32'(fwd2), 32'(ef2));
    if (rf_write_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_write", 32'(rf_write_en), 32'd0);
      end else begin
        w = exp_wr.pop_front();
        chk("write_reg", 32'(rf_wreg), 32'(w.r));
        chk("write_data", 32'(rf_wdata), 32'(w.d));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    rf_stall = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
  endtask

  initial begin
    cyc(2);
    chk("reset_ready", 32'(wb_ready), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_en", 32'(rf_write_en), 32'd0);
    reset = 1'b0;
    cyc();

    // Single write: strobe for exactly one cycle after acceptance.
    push(1, 16'd15);
    cyc();
    wb_valid = 1'b0;
    cyc();
    chk("t2_en", 32'(rf_write_en), 32'd1);
    chk("t2_reg", 32'(rf_wreg), 32'd1);
    chk("t2_data", 32'(rf_wdata), 32'd15);
    cyc();
    chk("t2_en_off", 32'(rf_write_en), 32'd0);
    chk("t2_count", 32'(count), 32'd0);

    // Same register three times back to back; newest must forward.
    q_reg1 = 2'd1;
    push(1, 16'd15); cyc();
    push(1, 16'd10); cyc();
    push(1, 16'd20); cyc();
    wb_valid = 1'b0;
    chk("t3_hit1", 32'(hit1), 32'd1);
    chk("t3_fwd1", 32'(fwd1), 32'd20);
    cyc(4);

    // Stall fills the queue; fifth request is held.
    rf_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(AW'(i), DW'(16'h100 + i));
      cyc();
    end
    chk("t4_count_full", 32'(count), 32'd4);
    chk("t4_ready_full", 32'(wb_ready), 32'd0);
    idle();
    cyc(6);

    // Push and pop on the same edge, then flush drops a same-cycle push.
    rf_stall = 1'b1;
    push(2, 16'hA1); cyc();
    push(3, 16'hA2); cyc();
    rf_stall = 1'b0;
    push(0, 16'hA3); cyc();
    chk("t5_count_pushpop", 32'(count), 32'd2);
    flush = 1'b1;
    push(1, 16'hA4); cyc();
    chk("t5_count_flush", 32'(count), 32'd0);
    chk("t5_en_flush", 32'(rf_write_en), 32'd0);
    idle();
    cyc();
    chk("t5_en_after", 32'(rf_write_en), 32'd0);

    // Forwarding miss, then hit through queue and output stage.
    q_reg2 = 2'd3;
    cyc();
    chk("t6_hit2_miss", 32'(hit2), 32'd0);
    chk("t6_fwd2_miss", 32'(fwd2), 32'd0);
    push(3, 16'd7); cyc();
    wb_valid = 1'b0;
    chk("t6_hit2_q", 32'(hit2), 32'd1);
    chk("t6_fwd2_q", 32'(fwd2), 32'd7);
    cyc();
    chk("t6_fwd2_out", 32'(fwd2), 32'd7);
    cyc();
    chk("t6_hit2_gone", 32'(hit2), 32'd0);

    // Reset while draining with entries queued.
    rf_stall = 1'b1;
    push(0, 16'h11); cyc();
    push(1, 16'h22); cyc();
    push(2, 16'h33); cyc();
    rf_stall = 1'b0;
    wb_valid = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("t1_en_reset", 32'(rf_write_en), 32'd0);
    chk("t1_count_reset", 32'(count), 32'd0);
    cyc(2);
    reset = 1'b0;
    #1;
    chk("t1_ready_release", 32'(wb_ready), 32'd1);
    cyc();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      wb_valid = ($urandom_range(99) < 70);
      wb_reg   = AW'($urandom);
      wb_data  = DW'($urandom);
      rf_stall = ($urandom_range(99) < 30);
      flush    = ($urandom_range(99) < 3);
      q_reg1   = AW'($urandom);
      q_reg2   = AW'($urandom);
      if ($urandom_range(999) < 5) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end
      cyc();
    end

    idle();
    cyc(10);
    chk("scoreboard_drained", 32'(exp_wr.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
